// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the RV32I multi-cycle core: FSM states,
// opcodes, ImmSel / ALUSel / WBSel codes and instruction classes.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_SHAMT = 3'b001;
  localparam logic [2:0] IMM_S     = 3'b010;
  localparam logic [2:0] IMM_B     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_J     = 3'b101;

  // ALU codes are {funct7[5], funct3} so R-type decode is a straight copy.
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SLL    = 4'b0001;
  localparam logic [3:0] ALU_SLT    = 4'b0010;
  localparam logic [3:0] ALU_SLTU   = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_OR     = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_SRA    = 4'b1101;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Branch type is funct3 of the BRANCH opcode.
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [3:0] {
    CLS_OP      = 4'd0,
    CLS_OPIMM   = 4'd1,
    CLS_LUI     = 4'd2,
    CLS_AUIPC   = 4'd3,
    CLS_JAL     = 4'd4,
    CLS_JALR    = 4'd5,
    CLS_LOAD    = 4'd6,
    CLS_STORE   = 4'd7,
    CLS_BRANCH  = 4'd8,
    CLS_ILLEGAL = 4'd9
  } inst_class_t;

  // Reserved branch funct3 codes (010, 011) never take the branch.
  function automatic logic branch_taken(input logic [2:0] br_type,
                                        input logic br_eq,
                                        input logic br_lt);
    logic taken;
    taken = 1'b0;
    case (br_type)
      BR_EQ:          taken = br_eq;
      BR_NE:          taken = !br_eq;
      BR_LT, BR_LTU:  taken = br_lt;
      BR_GE, BR_GEU:  taken = !br_lt;
      default:        taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// rv32i_decode: pure combinational instruction decode. Classifies the
// opcode and derives ImmSel, ALUSel, BrUn and the branch type; the FSM
// decides when these are allowed to reach the datapath.
module rv32i_decode
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output inst_class_t inst_class,
  output logic [2:0]  imm_sel,
  output logic [3:0]  alu_sel,
  output logic        br_un,
  output logic [2:0]  br_type
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       is_shift_imm;
  logic       unused_fields;

  assign opcode       = inst[6:0];
  assign funct3       = inst[14:12];
  assign funct7_b5    = inst[30];
  assign is_shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);
  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_fields = ^{inst[31], inst[29:15], inst[11:7]};

  // Opcode classification and per-class select generation.
  always_comb begin
    inst_class = CLS_ILLEGAL;
    imm_sel    = IMM_I;
    alu_sel    = ALU_ADD;
    br_un      = 1'b0;
    br_type    = funct3;
    case (opcode)
      OPC_OP: begin
        inst_class = CLS_OP;
        alu_sel    = {funct7_b5, funct3};
      end
      OPC_OPIMM: begin
        inst_class = CLS_OPIMM;
        // Only SRAI carries funct7[5]; for ADDI etc. bit 30 is immediate.
        alu_sel    = {funct7_b5 & (funct3 == 3'b101), funct3};
        imm_sel    = is_shift_imm ? IMM_SHAMT : IMM_I;
      end
      OPC_LUI: begin
        inst_class = CLS_LUI;
        imm_sel    = IMM_U;
        alu_sel    = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        inst_class = CLS_AUIPC;
        imm_sel    = IMM_U;
      end
      OPC_JAL: begin
        inst_class = CLS_JAL;
        imm_sel    = IMM_J;
      end
      OPC_JALR: begin
        inst_class = CLS_JALR;
        imm_sel    = IMM_I;
      end
      OPC_LOAD: begin
        inst_class = CLS_LOAD;
        imm_sel    = IMM_I;
      end
      OPC_STORE: begin
        inst_class = CLS_STORE;
        imm_sel    = IMM_S;
      end
      OPC_BRANCH: begin
        inst_class = CLS_BRANCH;
        imm_sel    = IMM_B;
        br_un      = funct3[1];
      end
      default: inst_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I
// multi-cycle core. Optional macro ILLEGAL_TRAP_EN adds a sticky TRAP state
// for unsupported opcodes; without it they retire as a NOP.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   FETCH    | MemReq at PC, IR loaded on the MemReady cycle
//   DECODE   | immediate format / compare mode presented from Inst
//   EXEC     | ALU operation; branches resolve and retire here
//   MEM      | data access for LOAD/STORE, held until MemReady
//   WB       | register write + PC update, then back to FETCH
//   TRAP     | illegal opcode seen; Illegal=1, idle until Rst
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int WIDTH_INST_LENGTH   = 32,
  parameter int WIDTH_SEL_LENGTH    = 3,
  parameter int WIDTH_ALUSEL_LENGTH = 4
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [WIDTH_INST_LENGTH-1:0]   Inst,
  input  logic                           BrEq,
  input  logic                           BrLt,
  input  logic                           MemReady,
  output logic                           MemReq,
  output logic                           MemWEn,
  output logic                           IRWEn,
  output logic                           PCWEn,
  output logic                           PCSel,
  output logic [WIDTH_SEL_LENGTH-1:0]    ImmSel,
  output logic                           ASel,
  output logic                           BSel,
  output logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel,
  output logic                           BrUn,
  output logic                           RegWEn,
  output logic [1:0]                     WBSel,
  output logic                           Illegal
);

  state_t      state;
  state_t      state_next;

  inst_class_t dec_class;
  logic [2:0]  dec_imm_sel;
  logic [3:0]  dec_alu_sel;
  logic        dec_br_un;
  logic [2:0]  dec_br_type;

  logic        dec_asel;
  logic        dec_bsel;
  logic        is_store;
  logic        is_load;
  logic        is_jump;
  logic        taken;

  rv32i_decode u_decode (
    .inst       (Inst),
    .inst_class (dec_class),
    .imm_sel    (dec_imm_sel),
    .alu_sel    (dec_alu_sel),
    .br_un      (dec_br_un),
    .br_type    (dec_br_type)
  );

  // PC-relative classes use PC as operand A; everything but R-type uses imm.
  assign dec_asel = (dec_class == CLS_AUIPC) || (dec_class == CLS_JAL) ||
                    (dec_class == CLS_BRANCH);
  assign dec_bsel = (dec_class != CLS_OP) && (dec_class != CLS_ILLEGAL);
  assign is_store = (dec_class == CLS_STORE);
  assign is_load  = (dec_class == CLS_LOAD);
  assign is_jump  = (dec_class == CLS_JAL) || (dec_class == CLS_JALR);
  assign taken    = branch_taken(dec_br_type, BrEq, BrLt);

  // State register with synchronous reset to FETCH.
  always_ff @(posedge Clk) begin
    if (Rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        case (dec_class)
          CLS_LOAD, CLS_STORE: state_next = S_MEM;
          CLS_BRANCH:          state_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
          CLS_ILLEGAL:         state_next = S_TRAP;
`endif
          default:             state_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (MemReady) state_next = is_store ? S_FETCH : S_WB;
      end
      S_WB:     state_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_next = S_TRAP;
`endif
      default:  state_next = S_FETCH;
    endcase
  end

  // Output decode from state and Inst; everything forced low during Rst.
  always_comb begin
    MemReq  = 1'b0;
    MemWEn  = 1'b0;
    IRWEn   = 1'b0;
    PCWEn   = 1'b0;
    PCSel   = 1'b0;
    ImmSel  = '0;
    ASel    = 1'b0;
    BSel    = 1'b0;
    ALUSel  = '0;
    BrUn    = 1'b0;
    RegWEn  = 1'b0;
    WBSel   = '0;
    Illegal = 1'b0;
    if (!Rst) begin
      case (state)
        S_FETCH: begin
          MemReq = 1'b1;
          ASel   = 1'b1;
          IRWEn  = MemReady;
        end
        S_DECODE: begin
          ImmSel = dec_imm_sel;
          BrUn   = dec_br_un;
          ASel   = dec_asel;
          BSel   = dec_bsel;
        end
        S_EXEC: begin
          ImmSel = dec_imm_sel;
          BrUn   = dec_br_un;
          ASel   = dec_asel;
          BSel   = dec_bsel;
          ALUSel = dec_alu_sel;
          if (dec_class == CLS_BRANCH) begin
            PCWEn = 1'b1;
            PCSel = taken;
          end
        end
        S_MEM: begin
          ImmSel = dec_imm_sel;
          BSel   = dec_bsel;
          ALUSel = dec_alu_sel;
          MemReq = 1'b1;
          MemWEn = is_store;
          // Stores retire on the ready cycle; loads still need WB.
          PCWEn  = is_store & MemReady;
        end
        S_WB: begin
          ImmSel = dec_imm_sel;
          ASel   = dec_asel;
          BSel   = dec_bsel;
          ALUSel = dec_alu_sel;
          RegWEn = (dec_class != CLS_ILLEGAL);
          PCWEn  = 1'b1;
          PCSel  = is_jump;
          if (is_load)      WBSel = WB_MEM;
          else if (is_jump) WBSel = WB_PC4;
          else              WBSel = WB_ALU;
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: Illegal = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
